// File: rtl/stream_mux_ctrl.sv
// Frame sequencer in front of stream_mux: forwards lane beats, pads, drains, reports bytes.
// Optional stall statistics are built when STREAM_MUX_CTRL_STATS_EN is defined.
module stream_mux_ctrl #(
   parameter int                    NUM_LANES      = 8,
   parameter int                    LANE_WIDTH     = 8,
   parameter int                    OUT_WORDS      = 8,
   parameter int                    BYTE_CNT_WIDTH = 32,
   parameter logic [LANE_WIDTH-1:0] PAD_BYTE       = '0,
   parameter int                    DRAIN_BEATS    = NUM_LANES + 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_LANES-1:0]            lane_valid_i,
   input  logic [NUM_LANES*LANE_WIDTH-1:0] lane_data_i,
   input  logic                            lane_last_i,
   output logic                            ready_o,
   output logic [NUM_LANES-1:0]            mux_valid_o,
   output logic [NUM_LANES*LANE_WIDTH-1:0] mux_data_o,
   input  logic                            mux_ready_i,
   output logic                            frame_done_o,
   output logic [BYTE_CNT_WIDTH-1:0]       frame_bytes_o,
   output logic                            busy_o,
   output logic [31:0]                     stall_cnt_o
);

   localparam int DCW = (DRAIN_BEATS > 1) ? $clog2(DRAIN_BEATS) : 1;
   localparam logic [BYTE_CNT_WIDTH-1:0] ONE = BYTE_CNT_WIDTH'(1);
   localparam logic [BYTE_CNT_WIDTH-1:0] OW_MASK = BYTE_CNT_WIDTH'(OUT_WORDS - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_BEATS - 1);

   typedef enum logic [1:0] {
      ST_STREAM,
      ST_PAD,
      ST_DRAIN,
      ST_DONE
   } state_e;

   state_e                    state_q;
   logic [BYTE_CNT_WIDTH-1:0] cnt_q;
   logic [BYTE_CNT_WIDTH-1:0] cnt_d;
   logic [BYTE_CNT_WIDTH-1:0] final_q;
   logic [BYTE_CNT_WIDTH-1:0] frame_bytes_q;
   logic [DCW-1:0]            drain_q;
   logic                      frame_done_q;
   logic [BYTE_CNT_WIDTH-1:0] pop;
   logic [BYTE_CNT_WIDTH-1:0] pad_n;
   logic [NUM_LANES-1:0]      pad_mask;
   logic                      pad_any;

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         pop = pop + BYTE_CNT_WIDTH'(lane_valid_i[i]);
      end
   end

   assign cnt_d = cnt_q + pop;

   // Only the low bits of final matter, so padding survives counter wrap.
   assign pad_n   = (~final_q + ONE) & OW_MASK;
   assign pad_any = (pad_n != '0);

   always_comb begin
      pad_mask = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         pad_mask[i] = (BYTE_CNT_WIDTH'(i) < pad_n);
      end
   end

   always_comb begin
      ready_o     = 1'b0;
      mux_valid_o = '0;
      mux_data_o  = '0;
      unique case (state_q)
         ST_STREAM: begin
            ready_o     = mux_ready_i;
            mux_valid_o = lane_valid_i;
            mux_data_o  = lane_data_i;
         end
         ST_PAD: begin
            mux_valid_o = pad_mask;
            for (int i = 0; i < NUM_LANES; i++) begin
               mux_data_o[i*LANE_WIDTH +: LANE_WIDTH] = pad_mask[i] ? PAD_BYTE : '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_STREAM;
         cnt_q         <= '0;
         final_q       <= '0;
         frame_bytes_q <= '0;
         drain_q       <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         unique case (state_q)
            ST_STREAM: begin
               if (mux_ready_i) begin
                  cnt_q <= cnt_d;
                  if (lane_last_i) begin
                     final_q <= cnt_d;
                     state_q <= ST_PAD;
                  end
               end
            end
            ST_PAD: begin
               if (!pad_any || mux_ready_i) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (mux_ready_i) begin
                  if (drain_q == DRAIN_LAST) begin
                     drain_q      <= '0;
                     state_q      <= ST_DONE;
                     frame_done_q <= 1'b1;
                  end else begin
                     drain_q <= drain_q + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               frame_bytes_q <= final_q;
               cnt_q         <= '0;
               state_q       <= ST_STREAM;
            end
            default: state_q <= ST_STREAM;
         endcase
      end
   end

   assign frame_done_o  = frame_done_q;
   assign frame_bytes_o = frame_bytes_q;
   assign busy_o        = (state_q != ST_STREAM);

`ifdef STREAM_MUX_CTRL_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (state_q == ST_STREAM && (|lane_valid_i) &&
                   !mux_ready_i && stall_q != '1) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_stream_mux_ctrl.sv
// Directed bench for stream_mux_ctrl: vector table plus end-of-frame sequences.
// Stall counter expectation follows STREAM_MUX_CTRL_STATS_EN.
module tb_stream_mux_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [7:0]  lane_valid_i;
   logic [63:0] lane_data_i;
   logic        lane_last_i;
   logic        ready_o;
   logic [7:0]  mux_valid_o;
   logic [63:0] mux_data_o;
   logic        mux_ready_i;
   logic        frame_done_o;
   logic [31:0] frame_bytes_o;
   logic        busy_o;
   logic [31:0] stall_cnt_o;

   int vec_n  = 0;
   int miss_n = 0;

   always #5 clk_i = ~clk_i;

   stream_mux_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .lane_valid_i  (lane_valid_i),
      .lane_data_i   (lane_data_i),
      .lane_last_i   (lane_last_i),
      .ready_o       (ready_o),
      .mux_valid_o   (mux_valid_o),
      .mux_data_o    (mux_data_o),
      .mux_ready_i   (mux_ready_i),
      .frame_done_o  (frame_done_o),
      .frame_bytes_o (frame_bytes_o),
      .busy_o        (busy_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   typedef struct {
      logic        rdy;
      logic [7:0]  vld;
      logic [63:0] dat;
      logic        last;
      logic        e_rdy;
      logic [7:0]  e_vld;
      logic [63:0] e_dat;
      logic        e_done;
      logic        e_busy;
      logic [31:0] e_fb;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_n++;
      if (act !== exp) begin
         miss_n++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic add(input logic rdy, input logic [7:0] vld, input logic [63:0] dat,
                      input logic last, input logic e_rdy, input logic [7:0] e_vld,
                      input logic [63:0] e_dat, input logic e_done, input logic e_busy,
                      input logic [31:0] e_fb);
      vec_t v;
      v.rdy = rdy; v.vld = vld; v.dat = dat; v.last = last;
      v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dat = e_dat;
      v.e_done = e_done; v.e_busy = e_busy; v.e_fb = e_fb;
      vq.push_back(v);
   endtask

   task automatic beat(input logic [7:0] v, input logic [63:0] d, input logic l);
      lane_valid_i = v;
      lane_data_i  = d;
      lane_last_i  = l;
      mux_ready_i  = 1'b1;
      @(negedge clk_i);
      chk("beat.ready", 64'(ready_o), 64'd1);
      step();
   endtask

   // Leaves the upstream beat held until the DONE cycle to show it is refused.
   task automatic wait_done(output int lat, output int nonempty);
      lat = 0;
      nonempty = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk_i);
         if (frame_done_o) begin
            lat = c;
            lane_valid_i = '0;
            lane_last_i  = 1'b0;
            break;
         end
         if (mux_valid_o != '0) nonempty++;
         step();
      end
   endtask

   initial begin
      int lat;
      int ne;
      int dones;
      logic [31:0] exp_stall;

      rst_i        = 1'b1;
      lane_valid_i = '0;
      lane_data_i  = '0;
      lane_last_i  = 1'b0;
      mux_ready_i  = 1'b1;
      step();
      step();
      rst_i = 1'b0;

      // Reset state
      @(negedge clk_i);
      chk("rst.done", 64'(frame_done_o), 64'd0);
      chk("rst.fbytes", 64'(frame_bytes_o), 64'd0);
      chk("rst.busy", 64'(busy_o), 64'd0);
      chk("rst.stall", 64'(stall_cnt_o), 64'd0);
      chk("rst.ready_hi", 64'(ready_o), 64'd1);
      mux_ready_i = 1'b0;
      #1;
      chk("rst.ready_lo", 64'(ready_o), 64'd0);
      mux_ready_i = 1'b1;
      step();

      // Stall cycles, then frame: 0F, 01+last -> final 5, pad mask 07
      for (int i = 0; i < 6; i++)
         add(0, 8'hFF, 64'h1122334455667788, 0, 0, 8'hFF, 64'h1122334455667788, 0, 0, 0);
      add(1, 8'h0F, 64'hA1A2A3A4B1B2B3B4, 0, 1, 8'h0F, 64'hA1A2A3A4B1B2B3B4, 0, 0, 0);
      add(1, 8'h01, 64'hFFEEDDCCBBAA9988, 1, 1, 8'h01, 64'hFFEEDDCCBBAA9988, 0, 0, 0);
      add(1, 8'hFF, 64'hDEADBEEFDEADBEEF, 0, 0, 8'h07, 64'h0, 0, 1, 0);
      for (int i = 0; i < 10; i++)
         add(1, 8'hFF, 64'hDEADBEEFDEADBEEF, 0, 0, 8'h00, 64'h0, 0, 1, 0);
      add(1, 8'hFF, 64'hDEADBEEFDEADBEEF, 0, 0, 8'h00, 64'h0, 1, 1, 0);
      add(1, 8'h00, 64'h0, 0, 1, 8'h00, 64'h0, 0, 0, 5);

      for (int i = 0; i < vq.size(); i++) begin
         mux_ready_i  = vq[i].rdy;
         lane_valid_i = vq[i].vld;
         lane_data_i  = vq[i].dat;
         lane_last_i  = vq[i].last;
         @(negedge clk_i);
         chk($sformatf("v%0d.ready", i), 64'(ready_o), 64'(vq[i].e_rdy));
         chk($sformatf("v%0d.mvalid", i), 64'(mux_valid_o), 64'(vq[i].e_vld));
         chk($sformatf("v%0d.mdata", i), mux_data_o, vq[i].e_dat);
         chk($sformatf("v%0d.done", i), 64'(frame_done_o), 64'(vq[i].e_done));
         chk($sformatf("v%0d.busy", i), 64'(busy_o), 64'(vq[i].e_busy));
         chk($sformatf("v%0d.fbytes", i), 64'(frame_bytes_o), 64'(vq[i].e_fb));
         step();
      end

`ifdef STREAM_MUX_CTRL_STATS_EN
      exp_stall = 32'd6;
`else
      exp_stall = 32'd0;
`endif
      chk("stats.stall6", 64'(stall_cnt_o), 64'(exp_stall));

      // Three full beats, no pad, 10 drain beats
      beat(8'hFF, 64'h0101010101010101, 0);
      beat(8'hFF, 64'h0202020202020202, 0);
      lane_valid_i = 8'hFF;
      beat(8'hFF, 64'h0303030303030303, 1);
      lane_valid_i = 8'hFF;
      lane_data_i  = 64'h0404040404040404;
      wait_done(lat, ne);
      chk("full.latency", 64'(lat), 64'd12);
      chk("full.nonempty", 64'(ne), 64'd0);
      step();
      @(negedge clk_i);
      chk("full.done_once", 64'(frame_done_o), 64'd0);
      chk("full.fbytes", 64'(frame_bytes_o), 64'd24);
      step();

      // 0F+last -> pad mask 0F, mux stalled 4 cycles in PAD
      beat(8'h0F, 64'h5555555555555555, 1);
      lane_valid_i = '0;
      lane_last_i  = 1'b0;
      mux_ready_i  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         chk($sformatf("padst%0d.mvalid", i), 64'(mux_valid_o), 64'h0F);
         chk($sformatf("padst%0d.mdata", i), mux_data_o, 64'h0);
         chk($sformatf("padst%0d.ready", i), 64'(ready_o), 64'd0);
         step();
      end
      mux_ready_i = 1'b1;
      wait_done(lat, ne);
      chk("padst.latency", 64'(lat + 4), 64'd16);
      chk("padst.padbeats", 64'(ne), 64'd1);
      step();
      @(negedge clk_i);
      chk("padst.fbytes", 64'(frame_bytes_o), 64'd4);
      step();

      // Empty frame
      beat(8'h00, 64'h0, 1);
      wait_done(lat, ne);
      chk("empty.latency", 64'(lat), 64'd12);
      chk("empty.nonempty", 64'(ne), 64'd0);
      step();
      @(negedge clk_i);
      chk("empty.done_once", 64'(frame_done_o), 64'd0);
      chk("empty.fbytes", 64'(frame_bytes_o), 64'd0);
      step();

      // Reset mid-DRAIN aborts the frame
      beat(8'h07, 64'h0000000000AABBCC, 1);
      lane_valid_i = '0;
      lane_last_i  = 1'b0;
      for (int i = 0; i < 4; i++) step();
      @(negedge clk_i);
      chk("abort.busy_before", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("abort.busy", 64'(busy_o), 64'd0);
      chk("abort.ready", 64'(ready_o), 64'd1);
      chk("abort.fbytes", 64'(frame_bytes_o), 64'd0);
      chk("abort.stall", 64'(stall_cnt_o), 64'd0);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_i);
         if (frame_done_o) dones++;
         step();
      end
      chk("abort.no_done", 64'(dones), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
      $finish;
   end

endmodule
